// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared defaults, state encoding and entry width for the ALU op sequencer
//
// Purpose : defaults for queue depth and field widths, the sequencer state
//           encoding, and the width of one queued {func, operand A} entry.
// Ports   : none (package).

package alu_seq_pkg;

  localparam int DEPTH_DEF   = 8;
  localparam int OPW_DEF     = 3;
  localparam int AW_DEF      = 4;
  localparam int ENTRY_W_DEF = OPW_DEF + AW_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector for a level input
//
// Purpose : flags the first cycle of a 0->1 transition of sig_i, comparing
//           against the level registered on the previous clock.
// Ports   : clk    - rising-edge clock
//           resetn - synchronous active-low reset
//           sig_i  - level input
//           rise_o - high for the one cycle in which sig_i rises

module rise_detect (
  input  logic clk,
  input  logic resetn,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q, prev_d;
  logic arm_q, arm_d;

  // arm_q records that the input has been seen low since reset, so a level
  // that is already high when reset releases is not mistaken for an edge.
  always_comb begin
    prev_d = sig_i;
    arm_d  = arm_q | ~sig_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_q <= 1'b0;
      arm_q  <= ~sig_i;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  assign rise_o = sig_i & ~prev_q & arm_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - queues {func, operand A} pairs and replays them to an ALU
//
// Purpose : Push edges fill a small queue; a Start edge replays every entry
//           in write order, one ALU operation every other cycle, ending with
//           a one-cycle Done pulse. Replay leaves the queue intact.
// Ports   : Clock, Restn        - clock, synchronous active-low reset
//           Push, Start, Clear  - level controls (Push/Start act on rising edges)
//           Op_in, A_in         - entry to enqueue
//           Func, A_out, Load   - registered issue interface to the ALU
//           Busy, Done          - replay status
//           Count, Full, Empty, Ovf - queue status

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic           Clock,
  input  logic           Restn,
  input  logic           Push,
  input  logic           Start,
  input  logic           Clear,
  input  logic [OPW-1:0] Op_in,
  input  logic [AW-1:0]  A_in,
  output logic [OPW-1:0] Func,
  output logic [AW-1:0]  A_out,
  output logic           Load,
  output logic           Busy,
  output logic           Done,
  output logic [3:0]     Count,
  output logic           Full,
  output logic           Empty,
  output logic           Ovf
);

  localparam int EW = OPW + AW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic       push_rise;
  logic       start_rise;

  seq_state_t     state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     count_q, count_d;
  logic [OPW-1:0] func_q, func_d;
  logic [AW-1:0]  a_q, a_d;
  logic           load_q, load_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;

  logic [EW-1:0]  mem_q [DEPTH];
  logic [EW-1:0]  rd_entry;
  logic           wr_en;
  logic           full;
  logic           start_ok;

  rise_detect u_push_rise (
    .clk    (Clock),
    .resetn (Restn),
    .sig_i  (Push),
    .rise_o (push_rise)
  );

  rise_detect u_start_rise (
    .clk    (Clock),
    .resetn (Restn),
    .sig_i  (Start),
    .rise_o (start_rise)
  );

  assign full     = (count_q == DEPTH_C);
  // An accepted Start takes priority over a Push edge in the same cycle.
  assign start_ok = (state_q == IDLE) && start_rise && (count_q != 4'd0);

  // State register
  always_ff @(posedge Clock) begin
    if (!Restn) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (Clear) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_d = ISSUE;
            idx_d   = '0;
          end
        end
        ISSUE: state_d = GAP;
        GAP: begin
          // Count cannot change while busy, so count_q >= 1 here.
          if (idx_q < (count_q - 4'd1)) begin
            state_d = ISSUE;
            idx_d   = idx_q + 4'd1;
          end else begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered issue outputs, keyed on the
  // state being entered so Load/Func/A_out line up in the ISSUE cycle.
  assign rd_entry = mem_q[idx_d[IW-1:0]];

  always_comb begin
    load_d = (state_d == ISSUE);
    done_d = (state_d == DONE);
    func_d = func_q;
    a_d    = a_q;
    if (state_d == ISSUE) begin
      {func_d, a_d} = rd_entry;
    end
  end

  // Queue bookkeeping: pushes are honoured only in IDLE.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    if (Clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if ((state_q == IDLE) && push_rise && !start_ok) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        count_d = count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Restn) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      func_q  <= '0;
      a_q     <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      load_q  <= load_d;
      done_q  <= done_d;
      func_q  <= func_d;
      a_q     <= a_d;
    end
  end

  // Queue storage is deliberately not reset.
  always_ff @(posedge Clock) begin
    if (Restn && wr_en) begin
      mem_q[count_q[IW-1:0]] <= {Op_in, A_in};
    end
  end

  assign Func  = func_q;
  assign A_out = a_q;
  assign Load  = load_q;
  assign Done  = done_q;
  assign Busy  = (state_q != IDLE);
  assign Count = count_q;
  assign Full  = full;
  assign Empty = (count_q == 4'd0);
  assign Ovf   = ovf_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer

module tb_alu_op_sequencer;

  localparam int DEPTH = 8;
  localparam int OPW   = 3;
  localparam int AW    = 4;

  logic           Clock;
  logic           Restn;
  logic           Push;
  logic           Start;
  logic           Clear;
  logic [OPW-1:0] Op_in;
  logic [AW-1:0]  A_in;
  logic [OPW-1:0] Func;
  logic [AW-1:0]  A_out;
  logic           Load;
  logic           Busy;
  logic           Done;
  logic [3:0]     Count;
  logic           Full;
  logic           Empty;
  logic           Ovf;

  alu_op_sequencer #(.DEPTH(DEPTH), .OPW(OPW), .AW(AW)) dut (
    .Clock (Clock), .Restn (Restn), .Push (Push), .Start (Start), .Clear (Clear),
    .Op_in (Op_in), .A_in (A_in), .Func (Func), .A_out (A_out), .Load (Load),
    .Busy (Busy), .Done (Done), .Count (Count), .Full (Full), .Empty (Empty), .Ovf (Ovf)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: queue contents plus "cycles since the accepted Start".
  // Offset k=1,3,..,2N-1 issues entry (k-1)/2; k=2N+1 is the Done cycle.
  int q_op[$];
  int q_a[$];
  bit m_prev_push, m_prev_start;
  bit m_ovf, m_act;
  int m_k, m_n;
  int m_func, m_a;

  function automatic bit exp_load();
    return m_act && (m_k % 2 == 1) && (m_k <= 2 * m_n - 1);
  endfunction

  function automatic bit exp_done();
    return m_act && (m_k == 2 * m_n + 1);
  endfunction

  task automatic model_edge();
    bit pr, sr;
    pr = Push && !m_prev_push;
    sr = Start && !m_prev_start;
    m_prev_push  = Push;
    m_prev_start = Start;
    if (!Restn) begin
      q_op.delete(); q_a.delete();
      m_ovf = 0; m_act = 0; m_k = 0; m_func = 0; m_a = 0;
      return;
    end
    if (Clear) begin
      q_op.delete(); q_a.delete();
      m_ovf = 0; m_act = 0;
    end else if (m_act) begin
      m_k++;
      if (m_k > 2 * m_n + 1) m_act = 0;
    end else if (sr && q_op.size() > 0) begin
      m_act = 1; m_k = 1; m_n = q_op.size();
    end else if (pr) begin
      if (q_op.size() == DEPTH) m_ovf = 1;
      else begin
        q_op.push_back(int'(Op_in));
        q_a.push_back(int'(A_in));
      end
    end
    if (exp_load()) begin
      m_func = q_op[(m_k - 1) / 2];
      m_a    = q_a[(m_k - 1) / 2];
    end
  endtask

  int log_cyc[$];
  int log_op[$];
  int log_a[$];
  int done_cyc;

  task automatic clear_log();
    log_cyc.delete(); log_op.delete(); log_a.delete();
    done_cyc = -1;
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    cyc++;
    #1;
    chk("load",  int'(Load),  int'(exp_load()));
    chk("done",  int'(Done),  int'(exp_done()));
    chk("busy",  int'(Busy),  int'(m_act));
    chk("count", int'(Count), q_op.size());
    chk("full",  int'(Full),  int'(q_op.size() == DEPTH));
    chk("empty", int'(Empty), int'(q_op.size() == 0));
    chk("ovf",   int'(Ovf),   int'(m_ovf));
    chk("func",  int'(Func),  m_func);
    chk("a_out", int'(A_out), m_a);
    if (Load) begin
      log_cyc.push_back(cyc);
      log_op.push_back(int'(Func));
      log_a.push_back(int'(A_out));
    end
    if (Done) done_cyc = cyc;
  endtask

  task automatic push_entry(input int op, input int a);
    Op_in = 3'(op);
    A_in  = 4'(a);
    Push  = 1'b1;
    tick();
    Push  = 1'b0;
    tick();
  endtask

  int t;
  int s1_op[3] = '{0, 1, 6};
  int s1_a[3]  = '{3, 5, 15};

  initial begin
    Restn = 1'b0; Push = 1'b0; Start = 1'b0; Clear = 1'b0;
    Op_in = '0; A_in = '0;
    m_prev_push = 0; m_prev_start = 0;
    clear_log();
    tick(); tick();
    Restn = 1'b1;
    tick();

    // Three-entry replay
    push_entry(0, 3); push_entry(1, 5); push_entry(6, 15);
    clear_log();
    t = cyc; Start = 1'b1; tick(); Start = 1'b0;
    repeat (8) tick();
    chk("s1_nload", log_cyc.size(), 3);
    for (int i = 0; i < 3 && i < log_cyc.size(); i++) begin
      chk("s1_load_cyc", log_cyc[i], t + 1 + 2 * i);
      chk("s1_func", log_op[i], s1_op[i]);
      chk("s1_a", log_a[i], s1_a[i]);
    end
    chk("s1_done_cyc", done_cyc, t + 7);
    chk("s1_count", int'(Count), 3);

    // Clear in the middle of a replay
    t = cyc; Start = 1'b1; tick(); Start = 1'b0;
    tick(); tick();
    Clear = 1'b1; tick(); Clear = 1'b0;
    chk("s4_load", int'(Load), 0);
    chk("s4_busy", int'(Busy), 0);
    chk("s4_count", int'(Count), 0);
    chk("s4_func", int'(Func), 1);
    tick();

    // Start with an empty queue
    clear_log();
    Start = 1'b1; tick(); Start = 1'b0;
    repeat (4) tick();
    chk("s3_nload", log_cyc.size(), 0);
    chk("s3_done", done_cyc, -1);
    chk("s3_busy", int'(Busy), 0);

    // Overfill
    for (int i = 0; i < 9; i++) push_entry(i % 8, i + 1);
    chk("s2_count", int'(Count), 8);
    chk("s2_full", int'(Full), 1);
    chk("s2_ovf", int'(Ovf), 1);
    clear_log();
    Start = 1'b1; tick(); Start = 1'b0;
    repeat (18) tick();
    chk("s2_nload", log_cyc.size(), 8);
    if (log_cyc.size() == 8) begin
      chk("s2_e7_func", log_op[7], 7);
      chk("s2_e7_a", log_a[7], 8);
    end

    // Simultaneous Push and Start
    Clear = 1'b1; tick(); Clear = 1'b0; tick();
    push_entry(5, 10); push_entry(2, 7);
    clear_log();
    Op_in = 3'd3; A_in = 4'd3;
    t = cyc; Push = 1'b1; Start = 1'b1; tick();
    Push = 1'b0; Start = 1'b0;
    repeat (6) tick();
    chk("s5_nload", log_cyc.size(), 2);
    chk("s5_done_cyc", done_cyc, t + 5);
    chk("s5_count", int'(Count), 2);

    // Reset during GAP, Push held high through release
    Start = 1'b1; tick(); Start = 1'b0;
    tick();
    chk("s6_in_gap", int'(Busy && !Load), 1);
    Restn = 1'b0; Push = 1'b1; tick();
    chk("s6_load", int'(Load), 0);
    chk("s6_busy", int'(Busy), 0);
    chk("s6_done", int'(Done), 0);
    chk("s6_count", int'(Count), 0);
    chk("s6_func", int'(Func), 0);
    chk("s6_a", int'(A_out), 0);
    chk("s6_ovf", int'(Ovf), 0);
    Restn = 1'b1;
    repeat (3) tick();
    chk("s6_no_push", int'(Count), 0);
    Push = 1'b0; tick();
    Push = 1'b1; tick();
    chk("s6_fresh_push", int'(Count), 1);
    Push = 1'b0; tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      Restn = ($urandom_range(0, 299) != 0);
      Clear = ($urandom_range(0, 79) == 0);
      Push  = 1'($urandom_range(0, 1));
      Start = ($urandom_range(0, 11) == 0);
      Op_in = 3'($urandom);
      A_in  = 4'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
